// File: rtl/seq_divider_if.sv
// Handshake and result bundle for seq_divider.
// The sign signal exists only when DIV_SIGNED_EN is defined.
interface seq_divider_if;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
`ifdef DIV_SIGNED_EN
    logic        sign;
`endif
    logic        busy;
    logic        done;
    logic [15:0] Quot;
    logic [15:0] Rem;
    logic        DivZero;
    logic        Ofl;

    modport master (
`ifdef DIV_SIGNED_EN
        output sign,
`endif
        output start, A, B,
        input  busy, done, Quot, Rem, DivZero, Ofl
    );

    modport slave (
`ifdef DIV_SIGNED_EN
        input  sign,
`endif
        input  start, A, B,
        output busy, done, Quot, Rem, DivZero, Ofl
    );
endinterface

// File: rtl/seq_divider.sv
// 16-bit restoring sequential divider, one quotient bit per cycle.
// Define DIV_SIGNED_EN to add two's-complement division selected by bus.sign.
module seq_divider (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [15:0] quo_q, quo_d;
    logic [16:0] rem_q, rem_d;
    logic [15:0] divisor_q, divisor_d;
    logic        negQ_q, negQ_d;
    logic        negR_q, negR_d;
    logic [15:0] quotOut_q, quotOut_d;
    logic [15:0] remOut_q, remOut_d;
    logic        divZero_q, divZero_d;
    logic        ofl_q, ofl_d;

    logic        signOp;
    logic [15:0] absA;
    logic [15:0] absB;
    logic [16:0] shifted;
    logic [16:0] trial;
    logic        fits;

`ifdef DIV_SIGNED_EN
    assign signOp = bus.sign;
`else
    assign signOp = 1'b0;
`endif

    // Signed operation divides magnitudes; result signs are restored on the last iteration.
    assign absA    = (signOp && bus.A[15]) ? (~bus.A + 16'd1) : bus.A;
    assign absB    = (signOp && bus.B[15]) ? (~bus.B + 16'd1) : bus.B;
    assign shifted = {rem_q[15:0], quo_q[15]};
    assign trial   = shifted - {1'b0, divisor_q};
    assign fits    = rem_q[16] || (shifted >= {1'b0, divisor_q});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            negQ_q    <= 1'b0;
            negR_q    <= 1'b0;
            quotOut_q <= '0;
            remOut_q  <= '0;
            divZero_q <= 1'b0;
            ofl_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            negQ_q    <= negQ_d;
            negR_q    <= negR_d;
            quotOut_q <= quotOut_d;
            remOut_q  <= remOut_d;
            divZero_q <= divZero_d;
            ofl_q     <= ofl_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        negQ_d    = negQ_q;
        negR_d    = negR_q;
        quotOut_d = quotOut_q;
        remOut_d  = remOut_q;
        divZero_d = divZero_q;
        ofl_d     = ofl_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    divZero_d = 1'b0;
                    ofl_d     = signOp && (bus.A == 16'h8000) && (bus.B == 16'hFFFF);
                    quo_d     = absA;
                    rem_d     = '0;
                    divisor_d = absB;
                    negQ_d    = signOp && (bus.A[15] ^ bus.B[15]);
                    negR_d    = signOp && bus.A[15];
                    count_d   = '0;
                    if (bus.B == 16'd0) begin
                        divZero_d = 1'b1;
                        quotOut_d = 16'hFFFF;
                        remOut_d  = bus.A;
                        state_d   = DONE;
                    end else begin
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                quo_d   = {quo_q[14:0], fits};
                rem_d   = fits ? trial : shifted;
                count_d = count_q + 4'd1;
                if (count_q == 4'd15) begin
                    quotOut_d = negQ_q ? (~quo_d + 16'd1) : quo_d;
                    remOut_d  = negR_q ? (~rem_d[15:0] + 16'd1) : rem_d[15:0];
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.Quot    = quotOut_q;
    assign bus.Rem     = remOut_q;
    assign bus.DivZero = divZero_q;
    assign bus.Ofl     = ofl_q;

endmodule
